// File: rtl/branch_resolve_unit_if.sv
// Handshake and data bundle between decode, the comparator, fetch and the
// branch resolve unit. The unit binds to the slave modport; the surrounding
// pipeline (or a bench) drives the master side.
// Optional macro BR_RESOLVE_STATS_EN adds the statistics counters and clear.
interface branch_resolve_unit_if #(
    parameter int DATA_LENGTH = 32
);
    logic                   req_valid;
    logic                   req_ready;
    logic [2:0]             req_funct3;
    logic [DATA_LENGTH-1:0] req_rs1;
    logic [DATA_LENGTH-1:0] req_rs2;
    logic [DATA_LENGTH-1:0] req_pc;
    logic [DATA_LENGTH-1:0] req_imm;
    logic                   req_pred_taken;
    logic [DATA_LENGTH-1:0] cmp_num1;
    logic [DATA_LENGTH-1:0] cmp_num2;
    logic                   cmp_brun;
    logic                   cmp_breq;
    logic                   cmp_brlt;
    logic                   res_valid;
    logic                   res_taken;
    logic                   res_mispredict;
    logic                   res_illegal;
    logic                   redirect_valid;
    logic                   redirect_ready;
    logic [DATA_LENGTH-1:0] redirect_pc;
    logic                   flush_o;
`ifdef BR_RESOLVE_STATS_EN
    logic [31:0]            stat_branches;
    logic [31:0]            stat_mispredicts;
    logic                   stat_clear;
`endif

    modport slave (
        input  req_valid, req_funct3, req_rs1, req_rs2, req_pc, req_imm, req_pred_taken,
        input  cmp_breq, cmp_brlt, redirect_ready,
`ifdef BR_RESOLVE_STATS_EN
        input  stat_clear,
        output stat_branches, stat_mispredicts,
`endif
        output req_ready, cmp_num1, cmp_num2, cmp_brun,
        output res_valid, res_taken, res_mispredict, res_illegal,
        output redirect_valid, redirect_pc, flush_o
    );

    modport master (
        output req_valid, req_funct3, req_rs1, req_rs2, req_pc, req_imm, req_pred_taken,
        output cmp_breq, cmp_brlt, redirect_ready,
`ifdef BR_RESOLVE_STATS_EN
        output stat_clear,
        input  stat_branches, stat_mispredicts,
`endif
        input  req_ready, cmp_num1, cmp_num2, cmp_brun,
        input  res_valid, res_taken, res_mispredict, res_illegal,
        input  redirect_valid, redirect_pc, flush_o
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: takes one branch from decode, drives the external
// comparator for a settle cycle, resolves direction/target on the next cycle,
// and on a mispredict holds a redirect to fetch followed by a fixed flush.
// Optional macro BR_RESOLVE_STATS_EN adds branch/mispredict counters.
module branch_resolve_unit #(
    parameter int DATA_LENGTH  = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input logic clk,
    input logic rst_n,
    branch_resolve_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CMP, RESOLVE, REDIRECT, FLUSH} state_t;

    state_t                  state;
    state_t                  stateNext;
    logic [3:0]              flushCnt;
    logic [3:0]              flushCntNext;
    logic [DATA_LENGTH-1:0]  cmpNum1Q;
    logic [DATA_LENGTH-1:0]  cmpNum2Q;
    logic                    brunQ;
    logic [2:0]              funct3Q;
    logic [DATA_LENGTH-1:0]  pcQ;
    logic [DATA_LENGTH-1:0]  immQ;
    logic                    predTakenQ;
    logic [DATA_LENGTH-1:0]  redirectPcQ;
    logic                    takenC;
    logic                    illegalC;
    logic                    mispredictC;
    logic                    accept;
    logic                    handshake;

    // Direction decode from funct3 and the comparator flags; illegal codes resolve not-taken.
    function automatic logic branchTaken(input logic [2:0] funct3, input logic eq, input logic lt);
        case (funct3)
            3'b000:         return eq;
            3'b001:         return !eq;
            3'b100, 3'b110: return lt;
            3'b101, 3'b111: return !lt;
            default:        return 1'b0;
        endcase
    endfunction

    function automatic logic isIllegal(input logic [2:0] funct3);
        return funct3[2:1] == 2'b01;
    endfunction

    assign accept    = (state == IDLE) && bus.req_valid;
    assign handshake = (state == REDIRECT) && bus.redirect_ready;

    // Resolution is combinational on the flags during RESOLVE so res_valid lands two cycles after accept.
    always_comb begin
        takenC      = branchTaken(funct3Q, bus.cmp_breq, bus.cmp_brlt);
        illegalC    = isIllegal(funct3Q);
        mispredictC = takenC != predTakenQ;
    end

    // State and flush counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            flushCnt <= '0;
        end else begin
            state    <= stateNext;
            flushCnt <= flushCntNext;
        end
    end

    // Next-state logic; the flush counter is loaded on the redirect handshake.
    always_comb begin
        stateNext    = state;
        flushCntNext = flushCnt;
        case (state)
            IDLE:     if (bus.req_valid) stateNext = CMP;
            CMP:      stateNext = RESOLVE;
            RESOLVE:  stateNext = mispredictC ? REDIRECT : IDLE;
            REDIRECT: begin
                if (bus.redirect_ready) begin
                    stateNext    = FLUSH;
                    flushCntNext = 4'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                if (flushCnt == 4'd1) stateNext = IDLE;
                else                  flushCntNext = flushCnt - 4'd1;
            end
            default:  stateNext = IDLE;
        endcase
    end

    // Request capture on accept and redirect target capture in RESOLVE; operands are never cleared afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmpNum1Q    <= '0;
            cmpNum2Q    <= '0;
            brunQ       <= 1'b0;
            funct3Q     <= '0;
            pcQ         <= '0;
            immQ        <= '0;
            predTakenQ  <= 1'b0;
            redirectPcQ <= '0;
        end else begin
            if (accept) begin
                cmpNum1Q   <= bus.req_rs1;
                cmpNum2Q   <= bus.req_rs2;
                brunQ      <= bus.req_funct3[1];
                funct3Q    <= bus.req_funct3;
                pcQ        <= bus.req_pc;
                immQ       <= bus.req_imm;
                predTakenQ <= bus.req_pred_taken;
            end
            if (state == RESOLVE) begin
                redirectPcQ <= takenC ? (pcQ + immQ) : (pcQ + DATA_LENGTH'(4));
            end
        end
    end

    assign bus.req_ready      = (state == IDLE);
    assign bus.cmp_num1       = cmpNum1Q;
    assign bus.cmp_num2       = cmpNum2Q;
    assign bus.cmp_brun       = brunQ;
    assign bus.res_valid      = (state == RESOLVE);
    assign bus.res_taken      = (state == RESOLVE) && takenC;
    assign bus.res_mispredict = (state == RESOLVE) && mispredictC;
    assign bus.res_illegal    = (state == RESOLVE) && illegalC;
    assign bus.redirect_valid = (state == REDIRECT);
    assign bus.redirect_pc    = redirectPcQ;
    assign bus.flush_o        = (state == FLUSH);

`ifdef BR_RESOLVE_STATS_EN
    logic [31:0] statBranchesQ;
    logic [31:0] statMispredictsQ;

    // Resolution counters; a clear in the same cycle as a resolution wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            statBranchesQ    <= '0;
            statMispredictsQ <= '0;
        end else if (bus.stat_clear) begin
            statBranchesQ    <= '0;
            statMispredictsQ <= '0;
        end else if (state == RESOLVE) begin
            statBranchesQ <= statBranchesQ + 32'd1;
            if (mispredictC) statMispredictsQ <= statMispredictsQ + 32'd1;
        end
    end

    assign bus.stat_branches    = statBranchesQ;
    assign bus.stat_mispredicts = statMispredictsQ;
`endif

    logic unusedHandshake;
    assign unusedHandshake = handshake;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed branches push expected
// resolutions and redirect targets; a negedge monitor checks them as the unit
// presents them. Define BR_RESOLVE_STATS_EN to also exercise the counters.
module tb_branch_resolve_unit;
    localparam int DL = 32;
    localparam int FC = 2;

    typedef struct packed {
        logic taken;
        logic mis;
        logic ill;
        logic brun;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t resultQ[$];
    logic [DL-1:0] redirectQ[$];

    branch_resolve_unit_if #(.DATA_LENGTH(DL)) bus ();

    branch_resolve_unit #(.DATA_LENGTH(DL), .FLUSH_CYCLES(FC)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator model: equality and signed/unsigned less-than on the registered operands.
    always_comb begin
        bus.cmp_breq = (bus.cmp_num1 == bus.cmp_num2);
        bus.cmp_brlt = bus.cmp_brun ? (bus.cmp_num1 < bus.cmp_num2)
                                    : ($signed(bus.cmp_num1) < $signed(bus.cmp_num2));
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic checkResetOutputs(input string name);
        check({name, "_ready"}, 64'(bus.req_ready), 64'd1);
        check({name, "_ctl"}, 64'({bus.res_valid, bus.res_taken, bus.res_mispredict, bus.res_illegal,
                                   bus.redirect_valid, bus.flush_o, bus.cmp_brun}), 64'd0);
        check({name, "_operands"}, {bus.cmp_num1, bus.cmp_num2}, 64'd0);
        check({name, "_rpc"}, 64'(bus.redirect_pc), 64'd0);
    endtask

    // Monitor: pops one expected resolution per res_valid and checks any presented redirect target.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.res_valid) begin
            if (resultQ.size() == 0) begin
                check("res_unexpected", 64'd1, 64'd0);
            end else begin
                e = resultQ.pop_front();
                check("res_taken", 64'(bus.res_taken), 64'(e.taken));
                check("res_mispredict", 64'(bus.res_mispredict), 64'(e.mis));
                check("res_illegal", 64'(bus.res_illegal), 64'(e.ill));
                check("cmp_brun", 64'(bus.cmp_brun), 64'(e.brun));
            end
        end
        if (rst_n && bus.redirect_valid) begin
            if (redirectQ.size() == 0) check("redirect_unexpected", 64'd1, 64'd0);
            else check("redirect_pc", 64'(bus.redirect_pc), 64'(redirectQ[0]));
        end
    end

`ifdef BR_RESOLVE_STATS_EN
    bit clrAtResolve = 1'b0;
`endif

    // Issues one branch from a negedge and returns at the negedge of cycle 3.
    task automatic issue(input logic [2:0] f3, input logic [DL-1:0] rs1, input logic [DL-1:0] rs2,
                         input logic [DL-1:0] pc, input logic [DL-1:0] imm, input logic pred,
                         input logic eTaken, input logic eMis, input logic eIll, input logic eBrun,
                         input logic [DL-1:0] ePc, input bit earlyReady);
        int guard = 0;
        while (!bus.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", 64'(bus.req_ready), 64'd1);
        bus.req_funct3     = f3;
        bus.req_rs1        = rs1;
        bus.req_rs2        = rs2;
        bus.req_pc         = pc;
        bus.req_imm        = imm;
        bus.req_pred_taken = pred;
        bus.req_valid      = 1'b1;
        resultQ.push_back('{eTaken, eMis, eIll, eBrun});
        if (eMis) redirectQ.push_back(ePc);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("cycle1_res_valid", 64'(bus.res_valid), 64'd0);
        check("cycle1_busy", 64'(bus.req_ready), 64'd0);
        check("cycle1_cmp_num", {bus.cmp_num1, bus.cmp_num2}, {rs1, rs2});
        @(negedge clk);
        check("cycle2_res_valid", 64'(bus.res_valid), 64'd1);
        if (earlyReady) bus.redirect_ready = 1'b1;
`ifdef BR_RESOLVE_STATS_EN
        if (clrAtResolve) bus.stat_clear = 1'b1;
`endif
        @(negedge clk);
`ifdef BR_RESOLVE_STATS_EN
        bus.stat_clear = 1'b0;
`endif
        check("cycle3_redirect_valid", 64'(bus.redirect_valid), 64'(eMis));
        check("cycle3_ready", 64'(bus.req_ready), 64'(!eMis));
    endtask

    // Holds redirect_ready low for 'hold' REDIRECT cycles, completes the handshake, measures the flush.
    task automatic completeRedirect(input int hold);
        int cnt = 0;
        int guard = 0;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            check("redirect_held", 64'(bus.redirect_valid), 64'd1);
        end
        bus.redirect_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.redirect_ready = 1'b0;
        void'(redirectQ.pop_front());
        @(negedge clk);
        check("redirect_dropped", 64'(bus.redirect_valid), 64'd0);
        while (bus.flush_o && guard < 40) begin
            cnt++;
            guard++;
            @(negedge clk);
        end
        check("flush_len", 64'(cnt), 64'(FC));
        check("idle_after_flush", 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_funct3 = '0;
        bus.req_rs1 = '0;
        bus.req_rs2 = '0;
        bus.req_pc = '0;
        bus.req_imm = '0;
        bus.req_pred_taken = 1'b0;
        bus.redirect_ready = 1'b0;
`ifdef BR_RESOLVE_STATS_EN
        bus.stat_clear = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // BEQ correctly predicted taken.
        issue(3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 1, 0, 0, 0, 32'h120, 0);
        // BLTU 0xFFFFFFFF < 1 unsigned is false; predicted taken -> fallthrough redirect, ready held low 3 cycles.
        issue(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b1, 0, 1, 0, 1, 32'h204, 0);
        completeRedirect(3);
        // BLT -1 < 1 signed; target wraps to 0x10; fetch ready before the redirect appears.
        issue(3'b100, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0, 32'h20, 1'b0, 1, 1, 0, 0, 32'h10, 1);
        completeRedirect(0);
        // Illegal funct3 011 predicted taken.
        issue(3'b011, 32'd7, 32'd7, 32'h300, 32'h80, 1'b1, 0, 1, 1, 1, 32'h304, 0);
        completeRedirect(1);
        // BGE 1 >= -1 signed, negative immediate target.
        issue(3'b101, 32'd1, 32'hFFFF_FFFF, 32'h400, 32'hFFFF_FFF0, 1'b0, 1, 1, 0, 0, 32'h3F0, 0);
        completeRedirect(0);
        // BGEU 1 >= 0xFFFFFFFF unsigned is false; correctly predicted not taken.
        issue(3'b111, 32'd1, 32'hFFFF_FFFF, 32'h500, 32'h10, 1'b0, 0, 0, 0, 1, 32'h504, 0);
        // BNE equal operands, not taken, and illegal 010 predicted not taken.
        issue(3'b001, 32'd3, 32'd3, 32'h600, 32'h10, 1'b0, 0, 0, 0, 0, 32'h604, 0);
        issue(3'b010, 32'd3, 32'd9, 32'h700, 32'h10, 1'b0, 0, 0, 1, 1, 32'h704, 0);

        // Reset during the second flush cycle.
        issue(3'b000, 32'd1, 32'd2, 32'h800, 32'h40, 1'b1, 0, 1, 0, 0, 32'h804, 0);
        bus.redirect_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.redirect_ready = 1'b0;
        void'(redirectQ.pop_front());
        @(negedge clk);
        @(negedge clk);
        check("second_flush_cycle", 64'(bus.flush_o), 64'd1);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("rst_in_flush");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_flush", 64'({bus.flush_o, bus.req_ready}), 64'b01);

        // Reset while a redirect is pending.
        issue(3'b001, 32'd4, 32'd4, 32'h900, 32'h40, 1'b1, 0, 1, 0, 0, 32'h904, 0);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("rst_in_redirect");
        redirectQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_redirect", 64'({bus.redirect_valid, bus.flush_o, bus.req_ready}), 64'b001);

        // A fresh BNE after reset resolves taken as predicted.
        issue(3'b001, 32'd3, 32'd4, 32'hA00, 32'h40, 1'b1, 1, 0, 0, 0, 32'hA40, 0);

`ifdef BR_RESOLVE_STATS_EN
        // Counters restarted at the last reset; four more branches, two of them mispredicts.
        issue(3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 1, 0, 0, 0, 32'h120, 0);
        issue(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b1, 0, 1, 0, 1, 32'h204, 0);
        completeRedirect(0);
        issue(3'b001, 32'd3, 32'd3, 32'h600, 32'h10, 1'b0, 0, 0, 0, 0, 32'h604, 0);
        issue(3'b011, 32'd7, 32'd7, 32'h300, 32'h80, 1'b1, 0, 1, 1, 1, 32'h304, 0);
        completeRedirect(0);
        check("stat_branches", 64'(bus.stat_branches), 64'd5);
        check("stat_mispredicts", 64'(bus.stat_mispredicts), 64'd2);
        clrAtResolve = 1'b1;
        issue(3'b011, 32'd7, 32'd7, 32'h300, 32'h80, 1'b1, 0, 1, 1, 1, 32'h304, 0);
        clrAtResolve = 1'b0;
        check("stat_clear_wins", {bus.stat_branches, bus.stat_mispredicts}, 64'd0);
        completeRedirect(0);
`endif

        repeat (2) @(negedge clk);
        check("results_drained", 64'(resultQ.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
